mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported unified memory between instruction fetch (IF) and data access (MA).
// - Serialises the two requests, with data first because it belongs to the older instruction.
// - Drives the pipeline-wide busywait that freezes pc, if_id, id_ex, ex_mem and ma_wb.
// - Sits between the cpu top-level (PC_IF, DMEM_* nets) and the external memory model.
// PARAMETERS
// - ADDR_W  32  address width, memory and both requesters
// - DATA_W  32  data width, memory and both requesters
// PORTS
// - clk          in   1       pipeline clock, rising edge
// - rst          in   1       asynchronous, active-low reset
// - imem_req     in   1       IF fetch request (level)
// - imem_addr    in   ADDR_W  fetch address (PC_IF)
// - imem_rdata   out  DATA_W  fetched instruction (INST_IF)
// - dmem_read    in   4       [3]=read enable, [2:0]=funct3 (LB/LH/LW/LBU/LHU)
// - dmem_write   in   3       [2]=write enable, [1:0]=funct3[1:0] (SB/SH/SW)
// - dmem_addr    in   ADDR_W  data address (DMEM_ADDR_MA)
// - dmem_wdata   in   DATA_W  store data (DMEM_DATA_WRITE_MA)
// - dmem_rdata   out  DATA_W  load data (DMEM_DATA_READ_MA)
// - busywait     out  1       1 = freeze the pipeline this cycle
// - mem_read     out  1       memory read strobe
// - mem_write    out  1       memory write strobe
// - mem_size     out  3       funct3 passed to memory; 3'b010 for fetches
// - mem_addr     out  ADDR_W  memory address
// - mem_wdata    out  DATA_W  memory write data
// - mem_rdata    in   DATA_W  memory read data, valid when mem_ready=1
// - mem_ready    in   1       memory completion, sampled at posedge
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; mem_read, mem_write and busywait = 0;
//   mem_addr, mem_wdata, mem_size, imem_rdata and dmem_rdata = 0.
// - A reset mid-access drops the strobes immediately and loses the access.
// - FSM states: IDLE, D_ACC, I_ACC, RELEASE.
// - IDLE: busywait = imem_req | dmem_read[3] | dmem_write[2] (combinational).
//   - Next state: D_ACC if data pending, else I_ACC if imem_req, else IDLE.
// - D_ACC: mem_write=1 if dmem_write[2], else mem_read=1.
//   - Write wins if both enables are set; that case is illegal and is not latched.
//   - mem_addr=dmem_addr, mem_size=funct3, mem_wdata=dmem_wdata.
//   - Strobes and buses are registered on entry and held stable until mem_ready=1.
//   - On mem_ready: a read latches mem_rdata into dmem_rdata.
//   - Then go to I_ACC if imem_req, else RELEASE.
// - I_ACC: mem_read=1, mem_addr=imem_addr, mem_size=3'b010.
//   - On mem_ready: latch imem_rdata and go to RELEASE.
// - RELEASE: strobes=0, busywait=0 for exactly one cycle, so the pipeline advances
//   using the latched data. Always return to IDLE.
// - busywait=1 in D_ACC and I_ACC, including the mem_ready cycle.
// - Each access costs at least one cycle, even if mem_ready is already high on entry.
// - mem_ready is ignored in IDLE and RELEASE.
// - Requester inputs are stable while busywait=1 because the pipeline is frozen.
//   They are sampled every cycle in an access state.
// - Latency, request seen in IDLE to busywait low: 1 + Ld + Li cycles,
//   where Ld and Li are the cycles in D_ACC and I_ACC (each >= 1).
// - Latched outputs hold their value until overwritten by the next completed access of the same kind.
// - Writes never modify dmem_rdata.
// - Addresses pass through unmodified; alignment checking belongs to the memory.
// CONFIGURATION
// - MEM_PORT_ARBITER_PERF_EN defined: three extra outputs, each 32-bit.
//   - perf_stall_cycles: counts cycles with busywait=1.
//   - perf_dacc and perf_iacc: count completed D_ACC and I_ACC accesses.
//   - Counters reset to 0 and wrap from 32'hFFFFFFFF to 0.
// - Macro undefined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
// - Fetch only: imem_req=1, addr 0x10, mem_ready on the 2nd I_ACC cycle, rdata 0x00500093
//   -> busywait high for 3 cycles, then low 1 cycle, imem_rdata=0x00500093.
// - Load and fetch: dmem_read=4'b1010 (LW) @0x100, mem_ready immediate
//   -> D_ACC precedes I_ACC, mem_size 010 in both, dmem_rdata latched, busywait high 3 cycles.
// - Store: dmem_write=3'b110 (SW), wdata 0xDEADBEEF @0x200
//   -> mem_write=1 only in D_ACC, dmem_rdata unchanged, then I_ACC.
// - Slow memory: mem_ready held low 5 cycles in D_ACC
//   -> mem_addr, mem_wdata and mem_write stable throughout, busywait stays 1.
// - Reset mid-I_ACC: rst=0 asynchronously
//   -> mem_read and busywait drop before the next edge, state IDLE, outputs 0.
// - PERF build: 2 fetch-only transactions at Li=1 -> perf_stall_cycles=4, perf_iacc=2, perf_dacc=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Serialises data (MA) and fetch (IF) accesses onto one memory port and freezes the pipeline meanwhile.
// Latency 1+Ld+Li cycles, then one release cycle. Optional counters: define MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_rdata,
    input  logic [3:0]        dmem_read,
    input  logic [2:0]        dmem_write,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_dacc,
    output logic [31:0]       perf_iacc
`endif
);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RELEASE} state_t;

    state_t            state, next_state;
    logic              data_pend;
    logic              busy_raw;
    logic              nxt_read, nxt_write;
    logic [2:0]        nxt_size;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata;

    assign data_pend = dmem_read[3] | dmem_write[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (data_pend)     next_state = D_ACC;
                     else if (imem_req) next_state = I_ACC;
            D_ACC:   if (mem_ready)     next_state = imem_req ? I_ACC : RELEASE;
            I_ACC:   if (mem_ready)     next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Port controls are computed from the state being entered so they are registered
    // on entry and re-sampled every cycle the access is held.
    always_comb begin
        nxt_read  = 1'b0;
        nxt_write = 1'b0;
        nxt_size  = mem_size;
        nxt_addr  = mem_addr;
        nxt_wdata = mem_wdata;
        busy_raw  = 1'b0;
        case (next_state)
            D_ACC: begin
                nxt_write = dmem_write[2];
                nxt_read  = ~dmem_write[2];
                nxt_addr  = dmem_addr;
                nxt_wdata = dmem_wdata;
                nxt_size  = dmem_write[2] ? {1'b0, dmem_write[1:0]} : dmem_read[2:0];
            end
            I_ACC: begin
                nxt_read = 1'b1;
                nxt_addr = imem_addr;
                nxt_size = 3'b010;
            end
            default: ;
        endcase
        case (state)
            IDLE:          busy_raw = imem_req | data_pend;
            D_ACC, I_ACC:  busy_raw = 1'b1;
            default:       busy_raw = 1'b0;
        endcase
    end

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign busywait = rst & busy_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_size   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            imem_rdata <= '0;
            dmem_rdata <= '0;
        end else begin
            mem_read  <= nxt_read;
            mem_write <= nxt_write;
            mem_size  <= nxt_size;
            mem_addr  <= nxt_addr;
            mem_wdata <= nxt_wdata;
            if (state == D_ACC && mem_ready && mem_read)
                dmem_rdata <= mem_rdata;
            if (state == I_ACC && mem_ready)
                imem_rdata <= mem_rdata;
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_dacc         <= '0;
            perf_iacc         <= '0;
        end else begin
            if (busywait)                      perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (state == D_ACC && mem_ready)   perf_dacc         <= perf_dacc + 32'd1;
            if (state == I_ACC && mem_ready)   perf_iacc         <= perf_iacc + 32'd1;
        end
    end
`endif

endmodule
